// File: rtl/pio_in_if.sv
// CPU-side peripheral bus for the parallel input port: read/write strobes, write data,
// registered read word and interrupt request.
interface pio_in_if;
  logic        RD_EN;
  logic        WR_EN;
  logic [31:0] PData_in;
  logic [31:0] PData_out;
  logic        irq;

  modport master (output RD_EN, WR_EN, PData_in, input PData_out, irq);
  modport slave  (input RD_EN, WR_EN, PData_in, output PData_out, irq);
endinterface

// File: rtl/pio_in.sv
// Parallel input port: synchronises and debounces switches/buttons, latches sticky press
// events, serves a read-to-clear 32-bit word and a maskable irq. State updates on falling clk.
module pio_in #(
  parameter int          N_SW            = 16,
  parameter int          N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int          CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SW-1:0]  SW,
  input  logic [N_BTN-1:0] BTN,
  pio_in_if.slave          bus
);

  localparam int N = N_SW + N_BTN;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]     sync1_q, sync1_d;
  logic [N-1:0]     sync2_q, sync2_d;
  logic [N-1:0]     db_q, db_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [N_BTN-1:0] btn_prev_q, btn_prev_d;
  logic [N_BTN-1:0] evt_q, evt_d;
  logic [N_BTN-1:0] mask_q, mask_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;

  logic [N_BTN-1:0] rise;
  logic [15:0]      sw_pad;
  logic [4:0]       btn_pad;
  logic [4:0]       evt_pad;
  logic             unused_wdata;

  assign sw_pad       = 16'(db_q[N_SW-1:0]);
  assign btn_pad      = 5'(db_q[N-1:N_SW]);
  assign evt_pad      = 5'(evt_q);
  assign unused_wdata = ^bus.PData_in[31:N_BTN];

  always_comb begin
    sync1_d = {BTN, SW};
    sync2_d = sync1_q;
    db_d    = db_q;
    // A bit flips only after its synchronised level disagrees for DEBOUNCE_CYCLES edges in a row.
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    rise       = db_q[N-1:N_SW] & ~btn_prev_q;
    btn_prev_d = db_q[N-1:N_SW];
    mask_d     = bus.WR_EN ? bus.PData_in[N_BTN-1:0] : mask_q;
    // A rise coinciding with a read is kept for the next read.
    evt_d      = bus.RD_EN ? rise : (evt_q | rise);
    irq_d      = |(evt_d & mask_d);

    rdata_d = rdata_q;
    if (bus.RD_EN) begin
      rdata_d = {|((evt_q | rise) & mask_q), 5'b0, evt_pad, btn_pad, sw_pad};
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      btn_prev_q <= '0;
      evt_q      <= '0;
      mask_q     <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_q       <= db_d;
      btn_prev_q <= btn_prev_d;
      evt_q      <= evt_d;
      mask_q     <= mask_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.PData_out = rdata_q;
  assign bus.irq       = irq_q;

endmodule

// File: tb/tb_pio_in.sv
// Bench for pio_in with DEBOUNCE_CYCLES=4: directed scenarios plus a randomized run
// checked against a sliding-window debounce / sticky-flag reference model.
module tb_pio_in;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = '0;
  logic [4:0]  btn = '0;
  int          total = 0;
  int          bad = 0;

  pio_in_if bus ();

  pio_in #(.N_SW(16), .N_BTN(5), .DEBOUNCE_CYCLES(DB), .CNT_W(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .SW    (sw),
    .BTN   (btn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a bit flips once its raw level, seen two edges late, has opposed the
  // debounced value on each of the last DB edges.
  logic [20:0] h [0:DB];
  logic [20:0] m_db;
  logic [4:0]  m_prev, m_evt, m_mask, m_rise;
  logic [31:0] m_rdata;
  logic        m_irq;
  logic        m_stable;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= DB; j++) h[j] = '0;
      m_db = '0; m_prev = '0; m_evt = '0; m_mask = '0; m_rdata = '0; m_irq = 1'b0;
    end else begin
      m_rise = m_db[20:16] & ~m_prev;
      if (bus.RD_EN) m_rdata = {|((m_evt | m_rise) & m_mask), 5'b0, m_evt, m_db};
      m_evt = bus.RD_EN ? m_rise : (m_evt | m_rise);
      if (bus.WR_EN) m_mask = bus.PData_in[4:0];
      m_irq = |(m_evt & m_mask);
      m_prev = m_db[20:16];
      for (int b = 0; b < 21; b++) begin
        m_stable = 1'b1;
        for (int j = 1; j <= DB; j++) if (h[j][b] == m_db[b]) m_stable = 1'b0;
        if (m_stable) m_db[b] = ~m_db[b];
      end
      for (int j = DB; j > 0; j--) h[j] = h[j-1];
      h[0] = {btn, sw};
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
  endtask

  task automatic do_read(output logic [31:0] w);
    bus.RD_EN = 1'b1;
    @(posedge clk);
    bus.RD_EN = 1'b0;
    w = bus.PData_out;
  endtask

  task automatic do_write(input logic [4:0] m);
    bus.WR_EN = 1'b1;
    bus.PData_in = {$urandom, 5'(m)} ;
    @(posedge clk);
    bus.WR_EN = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] w;
    sw = 16'hFFFF; btn = '0; rst_n = 1'b0;
    tick(3);
    total++; if (bus.PData_out !== 32'h0) begin bad++; $display("FAIL reset_pdata got=%h want=0", bus.PData_out); end
    total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", bus.irq); end
    rst_n = 1'b1;
    tick(8);
    do_read(w);
    total++; if (w[15:0] !== 16'hFFFF) begin bad++; $display("FAIL reset_sw got=%h want=ffff", w[15:0]); end
    total++; if (w[25:21] !== 5'h0) begin bad++; $display("FAIL reset_evt got=%h want=0", w[25:21]); end
    total++; if (w !== m_rdata) begin bad++; $display("FAIL reset_word got=%h want=%h", w, m_rdata); end
  endtask

  task automatic test_glitch();
    logic [31:0] w;
    sw = '0;
    tick(10);
    btn[0] = 1'b1;
    tick(3);
    btn[0] = 1'b0;
    tick(10);
    do_read(w);
    total++; if (w[16] !== 1'b0 || w[21] !== 1'b0) begin bad++; $display("FAIL glitch got=%h want_b16_b21=0", w); end
    total++; if (w !== 32'h0) begin bad++; $display("FAIL glitch_word got=%h want=0", w); end
  endtask

  task automatic test_press();
    logic [31:0] w;
    do_write(5'b00001);
    btn[0] = 1'b1;
    tick(6);
    total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL press_irq_early got=%b want=0", bus.irq); end
    tick(1);
    total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL press_irq_rise got=%b want=1", bus.irq); end
    do_read(w);
    total++; if (w !== 32'h80210000) begin bad++; $display("FAIL press_read1 got=%h want=80210000", w); end
    do_read(w);
    total++; if (w !== 32'h00010000) begin bad++; $display("FAIL press_read2 got=%h want=00010000", w); end
    total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL press_irq_clr got=%b want=0", bus.irq); end
    btn[0] = 1'b0;
    tick(10);
    total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL release_irq got=%b want=0", bus.irq); end
  endtask

  task automatic test_collision();
    logic [31:0] w1, w2;
    btn[2] = 1'b1;
    tick(6);
    do_read(w1);
    do_read(w2);
    total++; if (w1[23] !== 1'b0) begin bad++; $display("FAIL collide_read1 got=%b want=0", w1[23]); end
    total++; if (w2[23] !== 1'b1) begin bad++; $display("FAIL collide_read2 got=%b want=1", w2[23]); end
    total++; if (w1 !== 32'h00040000) begin bad++; $display("FAIL collide_word1 got=%h want=00040000", w1); end
    btn[2] = 1'b0;
    tick(10);
  endtask

  task automatic test_mask();
    logic [31:0] w;
    do_write(5'b0);
    btn[1] = 1'b1;
    tick(10);
    btn[1] = 1'b0;
    tick(10);
    total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL mask_off_irq got=%b want=0", bus.irq); end
    do_write(5'b00010);
    total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL mask_on_irq got=%b want=1", bus.irq); end
    do_write(5'b0);
    total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL mask_clr_irq got=%b want=0", bus.irq); end
    do_read(w);
    total++; if (w[22] !== 1'b1) begin bad++; $display("FAIL mask_evt_kept got=%b want=1", w[22]); end
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    do_write(5'h1F);
    btn = 5'h1F;
    tick(10);
    total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL arst_pre_irq got=%b want=1", bus.irq); end
    btn = 5'h0;
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.PData_out !== 32'h0) begin bad++; $display("FAIL arst_pdata got=%h want=0", bus.PData_out); end
    total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL arst_irq got=%b want=0", bus.irq); end
    sw = 16'hA5A5;
    tick(2);
    rst_n = 1'b1;
    do_read(w);
    total++; if (w !== 32'h0) begin bad++; $display("FAIL arst_first_read got=%h want=0", w); end
    tick(8);
    do_read(w);
    total++; if (w !== 32'h0000A5A5) begin bad++; $display("FAIL arst_settled got=%h want=0000a5a5", w); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      total++;
      if (bus.PData_out !== m_rdata || bus.irq !== m_irq) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h/%b want=%h/%b", c, bus.PData_out, bus.irq, m_rdata, m_irq);
      end
      if ($urandom_range(15) == 0) sw = 16'($urandom);
      if ($urandom_range(5) == 0) btn[$urandom_range(4)] ^= 1'b1;
      bus.RD_EN = ($urandom_range(5) == 0);
      bus.WR_EN = ($urandom_range(9) == 0);
      bus.PData_in = $urandom;
    end
    bus.RD_EN = 1'b0;
    bus.WR_EN = 1'b0;
  endtask

  initial begin
    bus.RD_EN = 1'b0;
    bus.WR_EN = 1'b0;
    bus.PData_in = '0;
    test_reset();
    test_glitch();
    test_press();
    test_collision();
    test_mask();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
